// File: rtl/bcd_digit_packer.sv
// bcd_digit_packer
// Collects decimal digits one at a time and packs a one- or two-digit entry
// into a packed-BCD byte {tens, units} for the downstream bcd_to_binary stage.
// Digits above 9 are dropped with a one-cycle err_digit pulse. A completed
// entry whose value exceeds MAX_VALUE is discarded with a one-cycle err_range
// pulse. An accepted word is held on a valid/ready port until it is taken.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   digit_in     candidate decimal digit (4 bits)
//   digit_valid  digit_in is presented this cycle
//   digit_ready  a digit can be accepted this cycle (state-decoded)
//   enter        finish a one-digit entry
//   clear        synchronous abort of any entry or pending word
//   bcd_out      packed BCD {tens, units}
//   bcd_valid    bcd_out holds a completed in-range word (state-decoded)
//   bcd_ready    downstream takes bcd_out
//   err_digit    one-cycle pulse: digit > 9 presented and dropped
//   err_range    one-cycle pulse: completed value > MAX_VALUE, entry dropped
//   digit_count  digits held: 0 EMPTY, 1 HAVE1, 2 OUT
module bcd_digit_packer #(
    parameter int MAX_VALUE = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    input  logic       enter,
    input  logic       clear,
    output logic [7:0] bcd_out,
    output logic       bcd_valid,
    input  logic       bcd_ready,
    output logic       err_digit,
    output logic       err_range,
    output logic [1:0] digit_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HAVE1 = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [6:0] MAX_V = 7'(MAX_VALUE);

    state_t     state_r;
    logic [3:0] tens_r;
    logic [3:0] units_r;
    logic [7:0] bcd_out_r;
    logic       err_digit_r;
    logic       err_range_r;

    logic [3:0] cand_tens_s;
    logic [3:0] cand_units_s;
    logic [6:0] value_s;
    logic       digit_ok_s;
    logic       in_range_s;

    // Decimal value of a two-digit BCD pair; 99 is the largest result.
    function automatic logic [6:0] bcd_value(input logic [3:0] t, input logic [3:0] u);
        return ({3'd0, t} * 7'd10) + {3'd0, u};
    endfunction

    // Candidate word for a completing edge in HAVE1: a second digit shifts the
    // held digit into tens, a bare enter completes with tens forced to zero.
    always_comb begin
        cand_tens_s  = 4'd0;
        cand_units_s = units_r;
        if (digit_valid) begin
            cand_tens_s  = units_r;
            cand_units_s = digit_in;
        end else begin
            cand_tens_s  = 4'd0;
            cand_units_s = units_r;
        end
        value_s    = bcd_value(cand_tens_s, cand_units_s);
        digit_ok_s = (digit_in <= 4'd9);
        in_range_s = (value_s <= MAX_V);
    end

    // Entry FSM with registered word and error pulses; clear overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            tens_r      <= 4'd0;
            units_r     <= 4'd0;
            bcd_out_r   <= 8'h00;
            err_digit_r <= 1'b0;
            err_range_r <= 1'b0;
        end else begin
            err_digit_r <= 1'b0;
            err_range_r <= 1'b0;
            if (clear) begin
                state_r   <= EMPTY;
                tens_r    <= 4'd0;
                units_r   <= 4'd0;
                bcd_out_r <= 8'h00;
            end else begin
                case (state_r)
                    EMPTY: begin
                        // enter is meaningless with no digit held
                        if (digit_valid) begin
                            if (digit_ok_s) begin
                                units_r <= digit_in;
                                tens_r  <= 4'd0;
                                state_r <= HAVE1;
                            end else begin
                                err_digit_r <= 1'b1;
                            end
                        end
                    end
                    HAVE1: begin
                        if (digit_valid && !digit_ok_s) begin
                            // bad digit dropped, held digit survives
                            err_digit_r <= 1'b1;
                        end else if (digit_valid || enter) begin
                            tens_r  <= cand_tens_s;
                            units_r <= cand_units_s;
                            if (in_range_s) begin
                                bcd_out_r <= {cand_tens_s, cand_units_s};
                                state_r   <= OUT;
                            end else begin
                                err_range_r <= 1'b1;
                                state_r     <= EMPTY;
                            end
                        end
                    end
                    OUT: begin
                        if (bcd_ready) begin
                            state_r <= EMPTY;
                        end
                    end
                    default: begin
                        state_r <= EMPTY;
                    end
                endcase
            end
        end
    end

    // Handshake flags and digit count decoded from registered state only.
    always_comb begin
        digit_ready = (state_r != OUT);
        bcd_valid   = (state_r == OUT);
        case (state_r)
            EMPTY:   digit_count = 2'd0;
            HAVE1:   digit_count = 2'd1;
            OUT:     digit_count = 2'd2;
            default: digit_count = 2'd0;
        endcase
    end

    assign bcd_out   = bcd_out_r;
    assign err_digit = err_digit_r;
    assign err_range = err_range_r;

endmodule
